// File: rtl/sram_ctrl.sv
// Single-port SRAM controller: a valid/ready host port is turned into one-cycle
// SRAM accesses, with read responses held until the host accepts them.
module sram_ctrl #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DEPTH_LOG-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 rsp_err,
    output logic                 err_pulse,
    output logic                 cs,
    output logic                 we,
    output logic [DEPTH_LOG-1:0] ad,
    output logic [WIDTH-1:0]     din,
    input  logic [WIDTH-1:0]     dout,
    output logic [15:0]          wr_cnt,
    output logic [15:0]          rd_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RSP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_we_q, req_we_d;
    logic                   oor_q, oor_d;
    logic                   cs_q, cs_d;
    logic                   we_q, we_d;
    logic                   err_pulse_q, err_pulse_d;
    logic [DEPTH_LOG-1:0]   ad_q, ad_d;
    logic [WIDTH-1:0]       din_q, din_d;
    logic [15:0]            wr_cnt_q, wr_cnt_d;
    logic [15:0]            rd_cnt_q, rd_cnt_d;
    logic                   accept_s;
    logic                   in_range_s;

    assign accept_s   = req_valid && (state_q == IDLE);
    assign in_range_s = (32'(req_addr) < 32'(DEPTH));

    // State and registered request/SRAM-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            oor_q       <= 1'b0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            err_pulse_q <= 1'b0;
            ad_q        <= '0;
            din_q       <= '0;
            wr_cnt_q    <= 16'd0;
            rd_cnt_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            oor_q       <= oor_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            err_pulse_q <= err_pulse_d;
            ad_q        <= ad_d;
            din_q       <= din_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    // Next-state decode; ISSUE always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept_s ? ISSUE : IDLE;
            ISSUE:   state_d = req_we_q ? IDLE : RSP;
            RSP:     state_d = rsp_ready ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; cs/we are set on acceptance so they are high during ISSUE
    always_comb begin
        req_we_d    = req_we_q;
        oor_d       = oor_q;
        ad_d        = ad_q;
        din_d       = din_q;
        cs_d        = accept_s && in_range_s;
        we_d        = accept_s && in_range_s && req_we;
        err_pulse_d = accept_s && !in_range_s;
        if (accept_s) begin
            req_we_d = req_we;
            oor_d    = !in_range_s;
            ad_d     = req_addr;
            din_d    = req_wdata;
        end else begin
            req_we_d = req_we_q;
            oor_d    = oor_q;
        end
        // Counters commit at the edge that ends ISSUE, so a reset during ISSUE discards the update
        if ((state_q == ISSUE) && !oor_q) begin
            wr_cnt_d = wr_cnt_q + {15'd0, req_we_q};
            rd_cnt_d = rd_cnt_q + {15'd0, !req_we_q};
        end else begin
            wr_cnt_d = wr_cnt_q;
            rd_cnt_d = rd_cnt_q;
        end
    end

    // Host-side outputs; read data comes straight from the SRAM output register, which holds in RSP
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RSP);
        rsp_err   = (state_q == RSP) && oor_q;
        if ((state_q == RSP) && !oor_q) begin
            rsp_rdata = dout;
        end else begin
            rsp_rdata = '0;
        end
        cs        = cs_q;
        we        = we_q;
        ad        = ad_q;
        din       = din_q;
        err_pulse = err_pulse_q;
        wr_cnt    = wr_cnt_q;
        rd_cnt    = rd_cnt_q;
    end

endmodule
